// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port arbiter bus: pipeline (A) and long-latency (B) requests,
// the shared write port, and the per-register pending-write hazard queries.
interface rf_write_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a transfer happens on a posedge where valid && ready; ready is
  // combinational from current inputs/state and valid must not wait on ready.
  logic          a_valid;
  logic [4:0]    a_sel;
  logic [31:0]   a_dat;
  logic          a_ready;
  logic          b_valid;
  logic [4:0]    b_sel;
  logic [31:0]   b_dat;
  logic          b_ready;
  logic          wen;
  logic [4:0]    wsel;
  logic [31:0]   wdat;
  logic [4:0]    q_sel1;
  logic [4:0]    q_sel2;
  logic          q_pend1;
  logic          q_pend2;
  logic [CW-1:0] b_count;

  modport master (
    output a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, q_sel1, q_sel2,
    input  a_ready, b_ready, wen, wsel, wdat, q_pend1, q_pend2, b_count
  );

  modport slave (
    input  a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, q_sel1, q_sel2,
    output a_ready, b_ready, wen, wsel, wdat, q_pend1, q_pend2, b_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between the writeback stage (A, priority)
// and a FIFO of long-latency results (B) with bounded starvation of B.
module rf_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input logic               CLK,
  input logic               nRST,
  rf_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  logic [4:0]       sel_mem [DEPTH];
  logic [31:0]      dat_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic empty, full, waw, force_b;
  logic a_ready_i, b_ready_i, a_use, b_use, enq;
  logic hit_a, hit1, hit2;

  // Per-slot valid bits let the hazard search ignore slot order entirely.
  always_comb begin
    hit_a = 1'b0;
    hit1  = 1'b0;
    hit2  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && sel_mem[i] == bus.a_sel)  hit_a = 1'b1;
      if (vld[i] && sel_mem[i] == bus.q_sel1) hit1  = 1'b1;
      if (vld[i] && sel_mem[i] == bus.q_sel2) hit2  = 1'b1;
    end
  end

  assign empty     = (count == '0);
  assign full      = (count == CFULL);
  assign waw       = hit_a && (bus.a_sel != 5'd0);
  assign force_b   = !empty && (starve_cnt == SMAX);
  assign a_ready_i = nRST && !waw && !force_b;
  assign b_ready_i = nRST && !full;
  assign a_use     = bus.a_valid && a_ready_i && (bus.a_sel != 5'd0);
  assign b_use     = nRST && !empty && !a_use;
  assign enq       = bus.b_valid && b_ready_i && (bus.b_sel != 5'd0);

  always_comb begin
    bus.wen  = 1'b0;
    bus.wsel = 5'd0;
    bus.wdat = 32'd0;
    if (a_use) begin
      bus.wen  = 1'b1;
      bus.wsel = bus.a_sel;
      bus.wdat = bus.a_dat;
    end else if (b_use) begin
      bus.wen  = 1'b1;
      bus.wsel = sel_mem[rd_ptr];
      bus.wdat = dat_mem[rd_ptr];
    end
  end

  assign bus.a_ready = a_ready_i;
  assign bus.b_ready = b_ready_i;
  assign bus.q_pend1 = hit1 && (bus.q_sel1 != 5'd0);
  assign bus.q_pend2 = hit2 && (bus.q_sel2 != 5'd0);
  assign bus.b_count = count;

  always_ff @(posedge CLK) begin
    if (enq) begin
      sel_mem[wr_ptr] <= bus.b_sel;
      dat_mem[wr_ptr] <= bus.b_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      vld        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      // Enqueue never targets the popping slot: it only writes a free slot.
      if (b_use) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (enq) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      count <= count + CW'(enq) - CW'(b_use);
      if (empty || b_use)
        starve_cnt <= '0;
      else if (a_use && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: queue-based reference model compared every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_rf_write_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  rf_write_arbiter_if #(.DEPTH(DEPTH)) bus();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic drive_a(input logic v, input logic [4:0] s, input logic [31:0] d);
    bus.a_valid = v;
    bus.a_sel   = s;
    bus.a_dat   = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] s, input logic [31:0] d);
    bus.b_valid = v;
    bus.b_sel   = s;
    bus.b_dat   = d;
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds {sel, dat} of every buffered B write in arrival order.
  logic [36:0] exp_q[$];
  int          m_starve = 0;
  bit          started  = 0;
  bit          p_pop, p_enq, p_ause;
  logic [36:0] p_ent;

  always @(negedge CLK) begin
    bit          e_wen, e_ar, e_br, e_q1, e_q2, waw, frc;
    logic [4:0]  e_ws;
    logic [31:0] e_wd;
    if (started) begin
      e_wen = 0; e_ws = 0; e_wd = 0; e_ar = 0; e_br = 0;
      e_q1 = 0; e_q2 = 0; waw = 0;
      p_pop = 0; p_enq = 0; p_ause = 0;
      p_ent = {bus.b_sel, bus.b_dat};
      foreach (exp_q[i]) begin
        if (bus.a_sel != 0 && exp_q[i][36:32] == bus.a_sel) waw = 1;
        if (bus.q_sel1 != 0 && exp_q[i][36:32] == bus.q_sel1) e_q1 = 1;
        if (bus.q_sel2 != 0 && exp_q[i][36:32] == bus.q_sel2) e_q2 = 1;
      end
      if (nRST) begin
        frc    = (exp_q.size() > 0) && (m_starve == STARVE_MAX);
        e_ar   = !waw && !frc;
        e_br   = exp_q.size() < DEPTH;
        p_ause = bus.a_valid && e_ar && bus.a_sel != 0;
        p_pop  = exp_q.size() > 0 && !p_ause;
        p_enq  = bus.b_valid && e_br && bus.b_sel != 0;
        if (p_ause) begin
          e_wen = 1; e_ws = bus.a_sel; e_wd = bus.a_dat;
        end else if (p_pop) begin
          e_wen = 1; e_ws = exp_q[0][36:32]; e_wd = exp_q[0][31:0];
        end
      end
      chk("wen", 32'(bus.wen), 32'(e_wen));
      chk("wsel", 32'(bus.wsel), 32'(e_ws));
      chk("wdat", bus.wdat, e_wd);
      chk("a_ready", 32'(bus.a_ready), 32'(e_ar));
      chk("b_ready", 32'(bus.b_ready), 32'(e_br));
      chk("b_count", 32'(bus.b_count), exp_q.size());
      chk("q_pend1", 32'(bus.q_pend1), 32'(e_q1));
      chk("q_pend2", 32'(bus.q_pend2), 32'(e_q2));
    end
  end

  always @(posedge CLK) begin
    if (!nRST) begin
      exp_q.delete();
      m_starve = 0;
    end else if (started) begin
      if (exp_q.size() == 0 || p_pop) m_starve = 0;
      else if (p_ause && m_starve < STARVE_MAX) m_starve++;
      if (p_pop) void'(exp_q.pop_front());
      if (p_enq) exp_q.push_back(p_ent);
    end
    started = 1;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int waited;
    bus.q_sel1 = 0;
    bus.q_sel2 = 0;
    // Reset held with both requesters active.
    drive_a(1, 5'd2, 32'h22);
    drive_b(1, 5'd4, 32'h44);
    repeat (2) tick();
    sample();
    chk("rst_wen", 32'(bus.wen), 0);
    chk("rst_b_ready", 32'(bus.b_ready), 0);
    chk("rst_a_ready", 32'(bus.a_ready), 0);
    chk("rst_b_count", 32'(bus.b_count), 0);
    tick();
    nRST = 1;
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    sample();
    chk("rel_b_ready", 32'(bus.b_ready), 1);
    chk("rel_b_count", 32'(bus.b_count), 0);
    tick();

    // B only: write appears one cycle after enqueue.
    drive_b(1, 5'd5, 32'hDEADBEEF);
    bus.q_sel1 = 5'd5;
    bus.q_sel2 = 5'd3;
    sample();
    chk("bonly_enq_wen", 32'(bus.wen), 0);
    chk("bonly_enq_qpend", 32'(bus.q_pend1), 0);
    tick();
    drive_b(0, 0, 0);
    sample();
    chk("bonly_wen", 32'(bus.wen), 1);
    chk("bonly_wsel", 32'(bus.wsel), 5);
    chk("bonly_wdat", bus.wdat, 32'hDEADBEEF);
    chk("bonly_pop_qpend", 32'(bus.q_pend1), 1);
    tick();
    sample();
    chk("bonly_count_after", 32'(bus.b_count), 0);
    chk("bonly_qpend_after", 32'(bus.q_pend1), 0);
    tick();

    // Starvation: A sel=7 every cycle, one B entry sel=3.
    drive_a(1, 5'd7, 32'h70);
    drive_b(1, 5'd3, 32'h33);
    sample();
    chk("starve_c0_wsel", 32'(bus.wsel), 7);
    tick();
    drive_b(0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      drive_a(1, 5'd7, 32'h70 + 32'(k));
      sample();
      chk("starve_a_wsel", 32'(bus.wsel), 7);
      chk("starve_a_ready", 32'(bus.a_ready), 1);
      tick();
    end
    drive_a(1, 5'd7, 32'h75);
    sample();
    chk("starve_force_a_ready", 32'(bus.a_ready), 0);
    chk("starve_force_wsel", 32'(bus.wsel), 3);
    chk("starve_force_wdat", bus.wdat, 32'h33);
    tick();
    sample();
    chk("starve_resume_a_ready", 32'(bus.a_ready), 1);
    chk("starve_resume_wdat", bus.wdat, 32'h75);
    tick();
    drive_a(0, 0, 0);

    // WAW: buffered sel=9 blocks A sel=9 until it drains.
    drive_b(1, 5'd9, 32'h99);
    sample();
    tick();
    drive_b(0, 0, 0);
    drive_a(1, 5'd9, 32'hA9);
    sample();
    chk("waw_a_ready", 32'(bus.a_ready), 0);
    chk("waw_b_wsel", 32'(bus.wsel), 9);
    chk("waw_b_wdat", bus.wdat, 32'h99);
    tick();
    sample();
    chk("waw_a_after_ready", 32'(bus.a_ready), 1);
    chk("waw_a_after_wdat", bus.wdat, 32'hA9);
    tick();

    // Full: A saturates the port while B fills all DEPTH slots.
    for (int i = 0; i < DEPTH; i++) begin
      drive_a(1, 5'd1, 32'h100 + 32'(i));
      drive_b(1, 5'd10 + 5'(i), 32'hB0 + 32'(i));
      sample();
      chk("fill_b_ready", 32'(bus.b_ready), 1);
      tick();
    end
    drive_a(1, 5'd1, 32'h104);
    drive_b(1, 5'd14, 32'hB4);
    sample();
    chk("full_b_count", 32'(bus.b_count), 4);
    chk("full_b_ready", 32'(bus.b_ready), 0);
    waited = 0;
    do begin
      tick();
      drive_a(1, 5'd1, 32'h105);
      sample();
      waited++;
    end while (!bus.b_ready && waited < 8);
    chk("full_release_cycles", waited, 2);
    tick();
    drive_b(0, 0, 0);
    drive_a(0, 0, 0);
    waited = 0;
    do begin
      sample();
      waited++;
      if (bus.b_count != 0) tick();
    end while (bus.b_count != 0 && waited < 12);
    chk("drain_empty", 32'(bus.b_count), 0);
    tick();

    // Register 0 on both ports.
    drive_b(1, 5'd6, 32'h66);
    sample();
    tick();
    drive_b(0, 0, 0);
    drive_a(1, 5'd0, 32'h1234);
    sample();
    chk("r0_a_ready", 32'(bus.a_ready), 1);
    chk("r0_b_drain_wsel", 32'(bus.wsel), 6);
    chk("r0_b_drain_wdat", bus.wdat, 32'h66);
    tick();
    drive_a(0, 0, 0);
    drive_b(1, 5'd0, 32'h77);
    bus.q_sel1 = 5'd0;
    sample();
    chk("r0_b_ready", 32'(bus.b_ready), 1);
    tick();
    drive_b(0, 0, 0);
    sample();
    chk("r0_b_count", 32'(bus.b_count), 0);
    chk("r0_wen", 32'(bus.wen), 0);
    tick();

    // Mid-operation reset discards buffered entries.
    drive_a(1, 5'd2, 32'h200);
    drive_b(1, 5'd20, 32'h20);
    tick();
    drive_b(1, 5'd21, 32'h21);
    tick();
    drive_b(0, 0, 0);
    bus.q_sel2 = 5'd21;
    sample();
    chk("mid_q_pend2", 32'(bus.q_pend2), 1);
    tick();
    nRST = 0;
    drive_b(1, 5'd22, 32'h22);
    sample();
    chk("mid_rst_wen", 32'(bus.wen), 0);
    chk("mid_rst_a_ready", 32'(bus.a_ready), 0);
    tick();
    sample();
    chk("mid_rst_b_count", 32'(bus.b_count), 0);
    tick();
    nRST = 1;
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    sample();
    chk("mid_after_wen", 32'(bus.wen), 0);
    chk("mid_after_q_pend2", 32'(bus.q_pend2), 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
